// File: rtl/fb_pkg.sv
// Shared constants, pixel codes and FSM state type for the framebuffer write path.
package fb_pkg;

   localparam int unsigned FB_WIDTH  = 640;
   localparam int unsigned FB_HEIGHT = 480;
   localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
   localparam int unsigned ADDR_W    = 19;

   localparam logic [7:0] COR_VAZIO = 8'd0;
   localparam logic [7:0] COR_JOG1  = 8'd1;
   localparam logic [7:0] COR_JOG2  = 8'd2;

   typedef enum logic {CLEAR, RUN} fb_state_e;

endpackage

// File: rtl/fb_req_fifo.sv
// Per-player request queue: power-of-two depth, synchronous flush, push allowed when full
// provided a pop happens in the same cycle.
module fb_req_fifo #(
   parameter int unsigned Width = 27,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned    PtrW    = $clog2(Depth);
   localparam logic [PtrW:0]  FullCnt = (PtrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [PtrW:0]    cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FullCnt);
   assign rdata_o = mem_q[rptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PtrW'(1);
         if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
            2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer RAM write-port owner: zero sweep on reset/restart, then round-robin of two players.
// Define FB_ADDR_CHECK_EN to discard out-of-range requests and count them in drop_count.
module fb_write_arbiter #(
   parameter int unsigned FB_WIDTH   = fb_pkg::FB_WIDTH,
   parameter int unsigned FB_HEIGHT  = fb_pkg::FB_HEIGHT,
   parameter int unsigned ADDR_W     = fb_pkg::ADDR_W,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              reiniciar,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_data,
   input  logic              p2_valid,
   output logic              p2_ready,
   input  logic [ADDR_W-1:0] p2_addr,
   input  logic [DATA_W-1:0] p2_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [7:0]        drop_count
);
   import fb_pkg::fb_state_e;
   import fb_pkg::CLEAR;
   import fb_pkg::RUN;
   import fb_pkg::COR_VAZIO;

   localparam int unsigned       FbPixels = FB_WIDTH * FB_HEIGHT;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FbPixels - 1);
   localparam int unsigned       EntryW   = ADDR_W + DATA_W;

   fb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [1:0]        rein_sync_q;
   logic              rein_prev_q, rise;
   logic              prio_q, prio_d;   // 0: player 1 wins a tie
   logic              wr_en_q, wr_en_d, done_q, done_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [EntryW-1:0] f1_head, f2_head, head;
   logic              f1_full, f1_empty, f2_full, f2_empty;
   logic              pop1, pop2, grant2, flush;

   assign rise       = rein_sync_q[1] && !rein_prev_q;
   assign flush      = (state_q == CLEAR) || rise;
   assign p1_ready   = (state_q == RUN) && !rise && !f1_full;
   assign p2_ready   = (state_q == RUN) && !rise && !f2_full;
   assign clear_busy = (state_q == CLEAR);
   assign clear_done = done_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;

   fb_req_fifo #(.Width(EntryW), .Depth(FIFO_DEPTH)) u_fifo_p1 (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .flush_i (flush),
      .push_i  (p1_valid && p1_ready),
      .wdata_i ({p1_addr, p1_data}),
      .pop_i   (pop1),
      .rdata_o (f1_head),
      .full_o  (f1_full),
      .empty_o (f1_empty)
   );

   fb_req_fifo #(.Width(EntryW), .Depth(FIFO_DEPTH)) u_fifo_p2 (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .flush_i (flush),
      .push_i  (p2_valid && p2_ready),
      .wdata_i ({p2_addr, p2_data}),
      .pop_i   (pop2),
      .rdata_o (f2_head),
      .full_o  (f2_full),
      .empty_o (f2_empty)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= CLEAR;
         clr_ptr_q   <= '0;
         rein_sync_q <= '0;
         rein_prev_q <= 1'b0;
         prio_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         rein_sync_q <= {rein_sync_q[0], reiniciar};
         rein_prev_q <= rein_sync_q[1];
         prio_q      <= prio_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (rise) begin
         state_d   = CLEAR;
         clr_ptr_d = '0;
      end else if (state_q == CLEAR) begin
         if (clr_ptr_q == LastAddr) begin
            state_d   = RUN;
            clr_ptr_d = '0;
         end else begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
         end
      end
   end

`ifdef FB_ADDR_CHECK_EN
   logic [7:0] drop_q, drop_d;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) drop_q <= 8'd0;
      else       drop_q <= drop_d;
   end

   assign drop_count = drop_q;
`else
   assign drop_count = 8'd0;
`endif

   always_comb begin
      grant2    = 1'b0;
      pop1      = 1'b0;
      pop2      = 1'b0;
      head      = '0;
      prio_d    = prio_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
`ifdef FB_ADDR_CHECK_EN
      drop_d    = drop_q;
`endif
      // A restart edge beats any pending grant; the flushed request is simply lost.
      if (rise) begin
         prio_d = 1'b0;
      end else if (state_q == CLEAR) begin
         prio_d    = 1'b0;
         wr_en_d   = 1'b1;
         wr_addr_d = clr_ptr_q;
         wr_data_d = DATA_W'(COR_VAZIO);
         done_d    = (clr_ptr_q == LastAddr);
      end else if (!f1_empty || !f2_empty) begin
         grant2    = f1_empty || (!f2_empty && prio_q);
         pop1      = !grant2;
         pop2      = grant2;
         head      = grant2 ? f2_head : f1_head;
         prio_d    = !grant2;
         wr_en_d   = 1'b1;
         wr_addr_d = head[EntryW-1:DATA_W];
         wr_data_d = head[DATA_W-1:0];
`ifdef FB_ADDR_CHECK_EN
         if (32'(head[EntryW-1:DATA_W]) >= FbPixels) begin
            wr_en_d = 1'b0;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter on a reduced 40x30 framebuffer.
module tb_fb_write_arbiter;

   localparam int unsigned W     = 40;
   localparam int unsigned H     = 30;
   localparam int unsigned PIX   = W * H;
   localparam int unsigned AW    = 19;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
`ifdef FB_ADDR_CHECK_EN
   localparam bit Check = 1'b1;
`else
   localparam bit Check = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rein = 1'b0;
   logic          p1_valid = 1'b0, p2_valid = 1'b0;
   logic [AW-1:0] p1_addr = '0, p2_addr = '0;
   logic [DW-1:0] p1_data = '0, p2_data = '0;
   logic          p1_ready, p2_ready, wr_en, clear_busy, clear_done;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [7:0]    drop_count;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fb_write_arbiter #(
      .FB_WIDTH   (W),
      .FB_HEIGHT  (H),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLOCK_50   (clk),
      .reset      (rst),
      .reiniciar  (rein),
      .p1_valid   (p1_valid),
      .p1_ready   (p1_ready),
      .p1_addr    (p1_addr),
      .p1_data    (p1_data),
      .p2_valid   (p2_valid),
      .p2_ready   (p2_ready),
      .p2_addr    (p2_addr),
      .p2_data    (p2_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .clear_busy (clear_busy),
      .clear_done (clear_done),
      .drop_count (drop_count)
   );

   // Reference model: two request queues, a tie-break owner and the expected write slot.
   logic [AW+DW-1:0] mq1[$], mq2[$];
   bit               m_p2_next;
   bit               m_en;
   logic [AW-1:0]    m_addr;
   logic [DW-1:0]    m_data;
   int               m_drops;

   task automatic model_step();
      bit               acc1, acc2;
      int               who;
      logic [AW+DW-1:0] it;
      acc1 = p1_valid && (mq1.size() < DEPTH);
      acc2 = p2_valid && (mq2.size() < DEPTH);
      m_en = 1'b0;
      who = 0;
      if (mq1.size() > 0 && mq2.size() > 0) who = m_p2_next ? 2 : 1;
      else if (mq1.size() > 0) who = 1;
      else if (mq2.size() > 0) who = 2;
      if (who != 0) begin
         if (who == 1) it = mq1.pop_front();
         else          it = mq2.pop_front();
         m_p2_next = (who == 1);
         if (Check && int'(it[AW+DW-1:DW]) >= PIX) begin
            m_drops++;
         end else begin
            m_en   = 1'b1;
            m_addr = it[AW+DW-1:DW];
            m_data = it[DW-1:0];
         end
      end
      if (acc1) mq1.push_back({p1_addr, p1_data});
      if (acc2) mq2.push_back({p2_addr, p2_data});
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
         n_fail++; $display("FAIL reset_wr got en=%b addr=%0d data=%0d want 0/0/0", wr_en, wr_addr, wr_data);
      end
      n_cmp++; if (clear_busy !== 1'b1 || clear_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got busy=%b done=%b want 1/0", clear_busy, clear_done);
      end
      n_cmp++; if (drop_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_drop got %0d want 0", drop_count);
      end
      n_cmp++; if (p1_ready !== 1'b0 || p2_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready got %b%b want 00", p1_ready, p2_ready);
      end
      rst = 1'b0;
      for (int i = 0; i < PIX; i++) begin
         @(negedge clk);
         n_cmp++; if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== '0) begin
            n_fail++; $display("FAIL sweep_write i=%0d got en=%b addr=%0d data=%0d want 1/%0d/0", i, wr_en, wr_addr, wr_data, i);
         end
         n_cmp++; if (clear_done !== (i == PIX - 1) || clear_busy !== (i != PIX - 1)) begin
            n_fail++; $display("FAIL sweep_flags i=%0d got done=%b busy=%b", i, clear_done, clear_busy);
         end
         n_cmp++; if (p1_ready !== (i == PIX - 1) || p2_ready !== (i == PIX - 1)) begin
            n_fail++; $display("FAIL sweep_ready i=%0d got %b%b", i, p1_ready, p2_ready);
         end
      end
      @(negedge clk);
      n_cmp++; if (wr_en !== 1'b0 || clear_done !== 1'b0 || p1_ready !== 1'b1 || p2_ready !== 1'b1) begin
         n_fail++; $display("FAIL sweep_end got en=%b done=%b rdy=%b%b want 0/0/11", wr_en, clear_done, p1_ready, p2_ready);
      end
   endtask

   task automatic test_contention();
      int            j;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      for (int c = 1; c <= 10; c++) begin
         p1_valid = (c <= 4); p1_addr = AW'(100 + c - 1); p1_data = 8'd1;
         p2_valid = (c <= 4); p2_addr = AW'(200 + c - 1); p2_data = 8'd2;
         @(negedge clk);
         if (c >= 2 && c <= 9) begin
            j  = c - 2;
            ea = (j % 2 == 0) ? AW'(100 + j / 2) : AW'(200 + j / 2);
            ed = (j % 2 == 0) ? 8'd1 : 8'd2;
            n_cmp++; if (wr_en !== 1'b1 || wr_addr !== ea || wr_data !== ed) begin
               n_fail++; $display("FAIL contention_order slot=%0d got en=%b addr=%0d data=%0d want 1/%0d/%0d", j, wr_en, wr_addr, wr_data, ea, ed);
            end
         end else begin
            n_cmp++; if (wr_en !== 1'b0) begin
               n_fail++; $display("FAIL contention_idle c=%0d got en=%b want 0", c, wr_en);
            end
         end
      end
   endtask

   task automatic test_single();
      p1_valid = 1'b1; p1_addr = AW'(1000); p1_data = 8'd1;
      @(negedge clk);
      p1_valid = 1'b0;
      n_cmp++; if (wr_en !== 1'b0) begin
         n_fail++; $display("FAIL single_early got en=%b want 0", wr_en);
      end
      @(negedge clk);
      n_cmp++; if (wr_en !== 1'b1 || wr_addr !== AW'(1000) || wr_data !== 8'd1) begin
         n_fail++; $display("FAIL single_write got en=%b addr=%0d data=%0d want 1/1000/1", wr_en, wr_addr, wr_data);
      end
      @(negedge clk);
      n_cmp++; if (wr_en !== 1'b0) begin
         n_fail++; $display("FAIL single_once got en=%b want 0", wr_en);
      end
   endtask

   task automatic test_addr_check();
      p1_valid = 1'b1; p1_addr = AW'(PIX); p1_data = 8'd1;
      @(negedge clk);
      p1_valid = 1'b0;
      @(negedge clk);
      if (Check) begin
         n_cmp++; if (wr_en !== 1'b0 || drop_count !== 8'd1) begin
            n_fail++; $display("FAIL addr_drop got en=%b drop=%0d want 0/1", wr_en, drop_count);
         end
      end else begin
         n_cmp++; if (wr_en !== 1'b1 || wr_addr !== AW'(PIX) || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL addr_pass got en=%b addr=%0d drop=%0d want 1/%0d/0", wr_en, wr_addr, drop_count, PIX);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_restart();
      int k;
      for (int c = 0; c < 4; c++) begin
         p1_valid = 1'b1; p1_addr = AW'(300 + c); p1_data = 8'd1;
         p2_valid = 1'b1; p2_addr = AW'(400 + c); p2_data = 8'd2;
         rein = (c >= 1);
         @(negedge clk);
      end
      p1_valid = 1'b0; p2_valid = 1'b0;
      for (k = 0; k < 20 && clear_busy !== 1'b1; k++) @(negedge clk);
      n_cmp++; if (clear_busy !== 1'b1 || wr_en !== 1'b0) begin
         n_fail++; $display("FAIL restart_enter got busy=%b en=%b want 1/0", clear_busy, wr_en);
      end
      for (int i = 0; i < PIX; i++) begin
         @(negedge clk);
         n_cmp++; if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== '0) begin
            n_fail++; $display("FAIL restart_sweep i=%0d got en=%b addr=%0d data=%0d want 1/%0d/0", i, wr_en, wr_addr, wr_data, i);
         end
         n_cmp++; if (clear_done !== (i == PIX - 1) || p1_ready !== (i == PIX - 1) || p2_ready !== (i == PIX - 1)) begin
            n_fail++; $display("FAIL restart_flags i=%0d got done=%b rdy=%b%b", i, clear_done, p1_ready, p2_ready);
         end
      end
      rein = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if (wr_en !== 1'b0 || clear_busy !== 1'b0) begin
            n_fail++; $display("FAIL restart_flushed i=%0d got en=%b busy=%b want 0/0", i, wr_en, clear_busy);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_drop;
      mq1.delete(); mq2.delete();
      m_p2_next = 1'b0;
      m_en      = 1'b0;
      m_drops   = Check ? 1 : 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         n_cmp++; if (wr_en !== m_en || (m_en && (wr_addr !== m_addr || wr_data !== m_data))) begin
            n_fail++; $display("FAIL random_write c=%0d got en=%b addr=%0d data=%0d want en=%b addr=%0d data=%0d", c, wr_en, wr_addr, wr_data, m_en, m_addr, m_data);
         end
         n_cmp++; if (p1_ready !== (mq1.size() < DEPTH) || p2_ready !== (mq2.size() < DEPTH)) begin
            n_fail++; $display("FAIL random_ready c=%0d got %b%b want %b%b", c, p1_ready, p2_ready, mq1.size() < DEPTH, mq2.size() < DEPTH);
         end
         exp_drop = (m_drops > 255) ? 8'd255 : 8'(m_drops);
         n_cmp++; if (drop_count !== exp_drop) begin
            n_fail++; $display("FAIL random_drop c=%0d got %0d want %0d", c, drop_count, exp_drop);
         end
         if (c < 250) begin
            p1_valid = ($urandom_range(0, 9) < 9);
            p2_valid = ($urandom_range(0, 9) < 9);
         end else if (c < 550) begin
            p1_valid = ($urandom_range(0, 9) < 4);
            p2_valid = ($urandom_range(0, 9) < 4);
         end else begin
            p1_valid = 1'b0;
            p2_valid = 1'b0;
         end
         p1_addr = AW'($urandom_range(0, PIX + 39)); p1_data = DW'($urandom_range(0, 255));
         p2_addr = AW'($urandom_range(0, PIX + 39)); p2_data = DW'($urandom_range(0, 255));
         @(posedge clk);
         model_step();
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_addr_check();
      test_restart();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
